// File: rtl/uart_rx_frame_ctrl.sv
// Parses SOF/ADDR/LEN/PAYLOAD/CSUM frames from the UART RX byte stream and commits verified
// payloads to a register bank. Optional SOF resync in ADDR/LEN/CSUM: UART_FRAME_SOF_RESYNC_EN.
module uart_rx_frame_ctrl #(
    parameter logic [7:0] SofByte     = 8'hA5,
    parameter int         MaxLen      = 16,
    parameter int         TimeoutClks = 208340
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [7:0] RxByte,
    input  logic       RxValid,
    output logic       WrEn,
    output logic [7:0] WrAddr,
    output logic [7:0] WrData,
    input  logic       WrReady,
    output logic       Busy,
    output logic       FrameOk,
    output logic       FrameErr,
    output logic [2:0] ErrCode
);
    localparam int IdxW = (MaxLen > 1) ? $clog2(MaxLen) : 1;
    localparam int ToW  = (TimeoutClks > 1) ? $clog2(TimeoutClks) : 1;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StAddr    = 3'd1;
    localparam logic [2:0] StLen     = 3'd2;
    localparam logic [2:0] StPayload = 3'd3;
    localparam logic [2:0] StCsum    = 3'd4;
    localparam logic [2:0] StCommit  = 3'd5;

    localparam logic [2:0] ErrBadLen  = 3'd1;
    localparam logic [2:0] ErrCsum    = 3'd2;
    localparam logic [2:0] ErrOverrun = 3'd3;
    localparam logic [2:0] ErrTimeout = 3'd4;

    logic [2:0]     state, stateNxt;
    logic [7:0]     baseAddr, baseNxt;
    logic [7:0]     len, lenNxt;
    logic [7:0]     idx, idxNxt;
    logic [7:0]     sum, sumNxt;
    logic [ToW-1:0] toCnt, toCntNxt;
    logic           ovrPend, ovrPendNxt;
    logic           wrEnNxt, frameOkNxt, frameErrNxt;
    logic [7:0]     wrAddrNxt, wrDataNxt;
    logic [2:0]     errCodeNxt;
    logic           memWe;
    logic [7:0]     idxInc;
    logic           toExpired;
    logic           lastAccept;
    logic           sofAbort;
    logic [7:0]     payloadMem [MaxLen];

    assign idxInc     = idx + 8'd1;
    assign toExpired  = (toCnt == ToW'(TimeoutClks - 1));
    assign lastAccept = WrEn && WrReady && (idx == (len - 8'd1));

`ifdef UART_FRAME_SOF_RESYNC_EN
    assign sofAbort = RxValid && (RxByte == SofByte) &&
                      ((state == StAddr) || (state == StLen) || (state == StCsum));
`else
    assign sofAbort = 1'b0;
`endif

    // Next-state and next-output computation for the frame parser and commit sequencer.
    always_comb begin
        stateNxt    = state;
        baseNxt     = baseAddr;
        lenNxt      = len;
        idxNxt      = idx;
        sumNxt      = sum;
        toCntNxt    = toCnt;
        wrEnNxt     = WrEn;
        wrAddrNxt   = WrAddr;
        wrDataNxt   = WrData;
        frameOkNxt  = 1'b0;
        ovrPendNxt  = 1'b0;
        memWe       = 1'b0;
        // An overrun that collided with the final acceptance is reported one cycle late.
        frameErrNxt = ovrPend;
        errCodeNxt  = ovrPend ? ErrOverrun : 3'd0;

        case (state)
            StIdle: begin
                if (RxValid && (RxByte == SofByte)) begin
                    stateNxt = StAddr;
                    toCntNxt = '0;
                end else begin
                    stateNxt = StIdle;
                end
            end
            StAddr, StLen, StPayload, StCsum: begin
                if (sofAbort) begin
                    stateNxt = StAddr;
                    toCntNxt = '0;
                end else if (RxValid) begin
                    toCntNxt = '0;
                    case (state)
                        StAddr: begin
                            baseNxt  = RxByte;
                            sumNxt   = RxByte;
                            stateNxt = StLen;
                        end
                        StLen: begin
                            if ((RxByte == 8'd0) || (RxByte > 8'(MaxLen))) begin
                                frameErrNxt = 1'b1;
                                errCodeNxt  = ErrBadLen;
                                stateNxt    = StIdle;
                            end else begin
                                lenNxt   = RxByte;
                                sumNxt   = sum + RxByte;
                                idxNxt   = 8'd0;
                                stateNxt = StPayload;
                            end
                        end
                        StPayload: begin
                            memWe  = 1'b1;
                            sumNxt = sum + RxByte;
                            idxNxt = idxInc;
                            if (idxInc == len) begin
                                stateNxt = StCsum;
                            end else begin
                                stateNxt = StPayload;
                            end
                        end
                        default: begin
                            if (RxByte == sum) begin
                                stateNxt  = StCommit;
                                idxNxt    = 8'd0;
                                wrEnNxt   = 1'b1;
                                wrAddrNxt = baseAddr;
                                wrDataNxt = payloadMem[IdxW'(0)];
                            end else begin
                                frameErrNxt = 1'b1;
                                errCodeNxt  = ErrCsum;
                                stateNxt    = StIdle;
                            end
                        end
                    endcase
                end else if (toExpired) begin
                    frameErrNxt = 1'b1;
                    errCodeNxt  = ErrTimeout;
                    toCntNxt    = '0;
                    stateNxt    = StIdle;
                end else begin
                    toCntNxt = toCnt + ToW'(1);
                end
            end
            StCommit: begin
                if (lastAccept) begin
                    wrEnNxt    = 1'b0;
                    frameOkNxt = 1'b1;
                    stateNxt   = StIdle;
                    ovrPendNxt = RxValid;
                end else if (WrEn && WrReady) begin
                    idxNxt    = idxInc;
                    wrAddrNxt = baseAddr + idxInc;
                    wrDataNxt = payloadMem[idxInc[IdxW-1:0]];
                end else begin
                    stateNxt = StCommit;
                end
                if (RxValid && !lastAccept) begin
                    frameErrNxt = 1'b1;
                    errCodeNxt  = ErrOverrun;
                end else begin
                    frameErrNxt = frameErrNxt;
                end
            end
            default: begin
                stateNxt = StIdle;
                wrEnNxt  = 1'b0;
            end
        endcase
    end

    // Control state and registered outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= StIdle;
            baseAddr <= 8'd0;
            len      <= 8'd0;
            idx      <= 8'd0;
            sum      <= 8'd0;
            toCnt    <= '0;
            ovrPend  <= 1'b0;
            WrEn     <= 1'b0;
            WrAddr   <= 8'd0;
            WrData   <= 8'd0;
            Busy     <= 1'b0;
            FrameOk  <= 1'b0;
            FrameErr <= 1'b0;
            ErrCode  <= 3'd0;
        end else begin
            state    <= stateNxt;
            baseAddr <= baseNxt;
            len      <= lenNxt;
            idx      <= idxNxt;
            sum      <= sumNxt;
            toCnt    <= toCntNxt;
            ovrPend  <= ovrPendNxt;
            WrEn     <= wrEnNxt;
            WrAddr   <= wrAddrNxt;
            WrData   <= wrDataNxt;
            Busy     <= (stateNxt != StIdle);
            FrameOk  <= frameOkNxt;
            FrameErr <= frameErrNxt;
            ErrCode  <= errCodeNxt;
        end
    end

    // Payload buffer; contents are don't-care after reset.
    always_ff @(posedge Clk) begin
        if (memWe) begin
            payloadMem[idx[IdxW-1:0]] <= RxByte;
        end
    end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: random and directed frames checked against a
// frame-level reference model; a separate monitor pops expected writes and frame events.
module tb_uart_rx_frame_ctrl;
    localparam int         MaxLen = 16;
    localparam int         ToClks = 40;
    localparam logic [7:0] Sof    = 8'hA5;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic [7:0] RxByte = 8'd0;
    logic       RxValid = 1'b0;
    logic       WrReady = 1'b0;
    logic       WrEn, Busy, FrameOk, FrameErr;
    logic [7:0] WrAddr, WrData;
    logic [2:0] ErrCode;

    uart_rx_frame_ctrl #(.SofByte(Sof), .MaxLen(MaxLen), .TimeoutClks(ToClks)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .RxByte(RxByte), .RxValid(RxValid),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .WrReady(WrReady),
        .Busy(Busy), .FrameOk(FrameOk), .FrameErr(FrameErr), .ErrCode(ErrCode)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int passes = 0;
    logic [7:0]  txQ[$];
    logic [15:0] writeQ[$];
    int          evQ[$];   // 0 = FrameOk, 1..4 = FrameErr code
    bit monEn = 1'b0;
    bit holdReady = 1'b0;
    int readyPct = 100;
    int acceptCnt = 0;
    int stallAt = -1;
    int stallLeft = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reference model: derives the expected writes and frame event from the byte list alone.
    task automatic predict(input bit overrun);
        int i = 0;
        logic [7:0] a, l, s;
        while (i < txQ.size() && txQ[i] != Sof) i++;
        if (i >= txQ.size()) return;
        i++;
        if (i + 2 > txQ.size()) begin evQ.push_back(4); return; end
        a = txQ[i];
        l = txQ[i+1];
        i += 2;
        if (l == 8'd0 || l > MaxLen) begin evQ.push_back(1); return; end
        if (i + l + 1 > txQ.size()) begin evQ.push_back(4); return; end
        s = a + l;
        for (int k = 0; k < l; k++) s = s + txQ[i+k];
        if (txQ[i+l] != s) begin evQ.push_back(2); return; end
        for (int k = 0; k < l; k++) writeQ.push_back({8'(a + k), txQ[i+k]});
        if (overrun) evQ.push_back(3);
        evQ.push_back(0);
    endtask

    task automatic sendBytes(input int gapMax);
        for (int k = 0; k < txQ.size(); k++) begin
            RxByte = txQ[k];
            RxValid = 1'b1;
            tick();
            RxValid = 1'b0;
            repeat ($urandom_range(0, gapMax)) tick();
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((writeQ.size() != 0 || evQ.size() != 0) && n < 600) begin
            tick();
            n++;
        end
        if (n >= 600) begin
            checks++;
            $display("FAIL drain_timeout: %0d writes and %0d events still pending", writeQ.size(), evQ.size());
            writeQ.delete();
            evQ.delete();
        end
        repeat (2) tick();
        check("busy_after_frame", Busy, 0);
    endtask

    task automatic sendFrame(input bit overrun, input int gapMax);
        predict(overrun);
        sendBytes(gapMax);
        if (overrun) begin
            repeat (2) tick();
            RxByte = 8'h5A;
            RxValid = 1'b1;
            tick();
            RxValid = 1'b0;
            repeat (3) tick();
            holdReady = 1'b0;
        end
        drain();
    endtask

    task automatic buildRandom(output bit ovr);
        int kind = $urandom_range(0, 9);
        logic [7:0] b, l, s;
        ovr = 1'b0;
        txQ.delete();
        repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom);
            if (b == Sof) b = 8'h00;
            txQ.push_back(b);
        end
        txQ.push_back(Sof);
        b = 8'($urandom);
        txQ.push_back(b);
        s = b;
        if (kind == 0) begin
            l = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MaxLen + 1, 255));
            txQ.push_back(l);
            return;
        end
        l = 8'($urandom_range(1, MaxLen));
        txQ.push_back(l);
        s = s + l;
        for (int k = 0; k < l; k++) begin
            b = 8'($urandom);
            txQ.push_back(b);
            s = s + b;
        end
        if (kind == 2) s = s ^ 8'($urandom_range(1, 255));
        txQ.push_back(s);
        if (kind == 1) repeat ($urandom_range(1, l + 1)) void'(txQ.pop_back());
        if (kind == 3) ovr = 1'b1;
    endtask

    // WrReady driver: random acceptance, optional hold-off and a targeted stall.
    initial begin
        forever begin
            tick();
            if (holdReady) WrReady = 1'b0;
            else if (stallLeft > 0 && acceptCnt == stallAt) begin
                WrReady = 1'b0;
                stallLeft--;
            end else WrReady = ($urandom_range(0, 99) < readyPct);
        end
    end

    // Monitor: pops and compares whenever the DUT presents a write or a frame event.
    initial begin
        logic hp;
        logic [7:0] ha, hd;
        logic [15:0] w;
        int e;
        hp = 1'b0;
        forever begin
            @(negedge Clk);
            if (!monEn) hp = 1'b0;
            else begin
                if (FrameOk || FrameErr) check("ok_err_exclusive", FrameOk & FrameErr, 0);
                if (WrEn) begin
                    if (hp) begin
                        check("hold_addr", WrAddr, ha);
                        check("hold_data", WrData, hd);
                    end
                    if (WrReady) begin
                        acceptCnt++;
                        hp = 1'b0;
                        if (writeQ.size() == 0) begin
                            checks++;
                            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", WrAddr, WrData);
                        end else begin
                            w = writeQ.pop_front();
                            check("wr_addr", WrAddr, w[15:8]);
                            check("wr_data", WrData, w[7:0]);
                        end
                    end else begin
                        hp = 1'b1;
                        ha = WrAddr;
                        hd = WrData;
                    end
                end else hp = 1'b0;
                if (FrameOk) begin
                    check("writes_before_ok", writeQ.size(), 0);
                    if (evQ.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_frame_ok: got pulse, expected none");
                    end else begin
                        e = evQ.pop_front();
                        check("event_frame_ok", 0, e);
                    end
                end
                if (FrameErr) begin
                    if (evQ.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_frame_err: got code %0d, expected none", ErrCode);
                    end else begin
                        e = evQ.pop_front();
                        check("event_err_code", ErrCode, e);
                    end
                end
            end
        end
    end

    initial begin
        bit ovr;
        int cnt;
        repeat (3) tick();
        check("rst_wren", WrEn, 0);
        check("rst_busy", Busy, 0);
        check("rst_frameok", FrameOk, 0);
        check("rst_frameerr", FrameErr, 0);
        check("rst_errcode", ErrCode, 0);
        check("rst_wraddr", WrAddr, 0);
        check("rst_wrdata", WrData, 0);
        Rst_n = 1'b1;
        tick();
        monEn = 1'b1;

        txQ = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h79};
        sendFrame(1'b0, 0);
        stallAt = acceptCnt + 1;
        stallLeft = 5;
        sendFrame(1'b0, 0);
        check("stall_consumed", stallLeft, 0);

        txQ = '{8'hA5, 8'hFE, 8'h02, 8'hAA, 8'hBB, 8'h65};
        sendFrame(1'b0, 2);
        txQ = '{8'hA5, 8'h00, 8'h00};
        sendFrame(1'b0, 0);
        txQ = '{8'hA5, 8'h00, 8'h11};
        sendFrame(1'b0, 0);
        txQ = '{8'hA5, 8'h10, 8'h01, 8'h55, 8'h00};
        sendFrame(1'b0, 0);
        txQ = '{8'hA5, 8'h10, 8'h02, 8'h01};
        sendFrame(1'b0, 0);
        txQ = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h79};
        sendFrame(1'b0, 0);
        holdReady = 1'b1;
        sendFrame(1'b1, 0);

        readyPct = 70;
        repeat (40) begin
            buildRandom(ovr);
            if (ovr) holdReady = 1'b1;
            sendFrame(ovr, ovr ? 0 : 8);
        end

        holdReady = 1'b1;
        txQ = '{8'hA5, 8'h20, 8'h02, 8'h07, 8'h08, 8'h31};
        sendBytes(0);
        repeat (3) tick();
        check("commit_active", WrEn, 1);
        monEn = 1'b0;
        #2;
        Rst_n = 1'b0;
        #1;
        check("async_rst_wren", WrEn, 0);
        check("async_rst_busy", Busy, 0);
        holdReady = 1'b0;
        readyPct = 100;
        repeat (2) tick();
        Rst_n = 1'b1;
        monEn = 1'b1;
        cnt = 0;
        repeat (20) begin
            tick();
            if (WrEn) cnt++;
        end
        check("writes_after_reset", cnt, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
